// File: rtl/fetcher_pkg.sv
// rtl/fetcher_pkg.sv - shared constants, cache geometry helpers and fetch FSM states
package fetcher_pkg;
  localparam int DATA_WIDTH = 32;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;
  localparam int ICACHE_LINES_DEFAULT = 64;

  // Word-addressed, direct-mapped: pc[1:0] never reaches the index or tag.
  function automatic int icache_index_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int icache_tag_w(input int lines);
    return DATA_WIDTH - $clog2(lines) - 2;
  endfunction

  typedef enum logic [1:0] {IDLE, WAIT_MEM, HOLD} state_t;
endpackage

// File: rtl/fetcher_icache.sv
// rtl/fetcher_icache.sv - direct-mapped instruction cache, combinational lookup, one write port
module fetcher_icache
  import fetcher_pkg::*;
#(
  parameter int LINES = ICACHE_LINES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rd_addr,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);
  localparam int IW = icache_index_w(LINES);
  localparam int TW = icache_tag_w(LINES);

  logic [LINES-1:0]      valid;
  logic [TW-1:0]         tags [LINES];
  logic [DATA_WIDTH-1:0] data [LINES];

  logic [IW-1:0] rd_idx;
  logic [IW-1:0] wr_idx;
  logic [TW-1:0] rd_tag;
  logic [TW-1:0] wr_tag;

  assign rd_idx = rd_addr[IW+1:2];
  assign rd_tag = rd_addr[DATA_WIDTH-1:IW+2];
  assign wr_idx = wr_addr[IW+1:2];
  assign wr_tag = wr_addr[DATA_WIDTH-1:IW+2];

  always_comb begin
    hit     = valid[rd_idx] && (tags[rd_idx] == rd_tag);
    rd_data = data[rd_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= TRUE;
    end
  end

  // Only the valid bits need clearing; tag/data contents are don't-care until valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  end
endmodule

// File: rtl/fetcher.sv
// rtl/fetcher.sv - instruction fetcher with optional icache (enabled by macro FETCHER_ICACHE_EN)
module fetcher
  import fetcher_pkg::*;
#(
  parameter int ICACHE_LINES = ICACHE_LINES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  output logic                  out_mem_ce,
  output logic [DATA_WIDTH-1:0] out_mem_addr,
  input  logic                  in_mem_ce,
  input  logic [DATA_WIDTH-1:0] in_mem_data,
  input  logic                  in_queue_full,
  output logic                  out_inst_valid,
  output logic [DATA_WIDTH-1:0] out_inst,
  output logic [DATA_WIDTH-1:0] out_pc,
  input  logic                  in_rob_misbranch,
  input  logic [DATA_WIDTH-1:0] in_rob_newpc
);
  state_t                state;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] held_inst;
  logic                  hit;
  logic [DATA_WIDTH-1:0] hit_data;
  logic                  fill_en;

  // A response landing together with a misbranch still fills the cache; only delivery is dropped.
  assign fill_en = rdy && (state == WAIT_MEM) && in_mem_ce;

`ifdef FETCHER_ICACHE_EN
  fetcher_icache #(
    .LINES(ICACHE_LINES)
  ) u_icache (
    .clk    (clk),
    .rst    (rst),
    .rd_addr(pc),
    .hit    (hit),
    .rd_data(hit_data),
    .wr_en  (fill_en),
    .wr_addr(pc),
    .wr_data(in_mem_data)
  );
`else
  assign hit      = FALSE;
  assign hit_data = ZERO_DATA;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      pc             <= ZERO_DATA;
      held_inst      <= ZERO_DATA;
      out_mem_ce     <= FALSE;
      out_mem_addr   <= ZERO_DATA;
      out_inst_valid <= FALSE;
      out_inst       <= ZERO_DATA;
      out_pc         <= ZERO_DATA;
    end else if (rdy) begin
      out_mem_ce     <= FALSE;
      out_inst_valid <= FALSE;
      if (in_rob_misbranch) begin
        pc    <= in_rob_newpc;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (!in_queue_full) begin
              if (hit) begin
                out_inst_valid <= TRUE;
                out_inst       <= hit_data;
                out_pc         <= pc;
                pc             <= pc + 32'd4;
              end else begin
                out_mem_ce   <= TRUE;
                out_mem_addr <= pc;
                state        <= WAIT_MEM;
              end
            end
          end
          WAIT_MEM: begin
            if (in_mem_ce) begin
              if (!in_queue_full) begin
                out_inst_valid <= TRUE;
                out_inst       <= in_mem_data;
                out_pc         <= pc;
                pc             <= pc + 32'd4;
                state          <= IDLE;
              end else begin
                held_inst <= in_mem_data;
                state     <= HOLD;
              end
            end
          end
          HOLD: begin
            if (!in_queue_full) begin
              out_inst_valid <= TRUE;
              out_inst       <= held_inst;
              out_pc         <= pc;
              pc             <= pc + 32'd4;
              state          <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fetcher.sv
// tb/tb_fetcher.sv - directed self-checking bench for fetcher
module tb_fetcher;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        out_mem_ce;
  logic [31:0] out_mem_addr;
  logic        in_mem_ce = 1'b0;
  logic [31:0] in_mem_data = 32'h0;
  logic        in_queue_full = 1'b0;
  logic        out_inst_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        in_rob_misbranch = 1'b0;
  logic [31:0] in_rob_newpc = 32'h0;

  int checks = 0;
  int errors = 0;
  int ce_count = 0;
  int ce_snap;

  fetcher #(.ICACHE_LINES(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .out_mem_ce      (out_mem_ce),
    .out_mem_addr    (out_mem_addr),
    .in_mem_ce       (in_mem_ce),
    .in_mem_data     (in_mem_data),
    .in_queue_full   (in_queue_full),
    .out_inst_valid  (out_inst_valid),
    .out_inst        (out_inst),
    .out_pc          (out_pc),
    .in_rob_misbranch(in_rob_misbranch),
    .in_rob_newpc    (in_rob_newpc)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (out_mem_ce) ce_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    step();
    check("rst_ce", {31'b0, out_mem_ce}, 32'd0);
    check("rst_addr", out_mem_addr, 32'h0);
    check("rst_valid", {31'b0, out_inst_valid}, 32'd0);
    check("rst_inst", out_inst, 32'h0);
    check("rst_pc", out_pc, 32'h0);

    // cold miss at 0
    rst = 1'b0;
    step();
    check("cold_ce", {31'b0, out_mem_ce}, 32'd1);
    check("cold_addr", out_mem_addr, 32'h0);
    step();
    check("cold_ce_pulse", {31'b0, out_mem_ce}, 32'd0);
    check("cold_addr_hold", out_mem_addr, 32'h0);
    in_mem_ce = 1'b1; in_mem_data = 32'h00500093;
    step();
    in_mem_ce = 1'b0;
    check("cold_valid", {31'b0, out_inst_valid}, 32'd1);
    check("cold_inst", out_inst, 32'h00500093);
    check("cold_pc", out_pc, 32'h0);
    step();
    check("next_valid", {31'b0, out_inst_valid}, 32'd0);
    check("next_ce", {31'b0, out_mem_ce}, 32'd1);
    check("next_addr", out_mem_addr, 32'h4);

    // flush in WAIT_MEM redirects to 0x100 (same index as 0x0)
    in_rob_misbranch = 1'b1; in_rob_newpc = 32'h100;
    step();
    in_rob_misbranch = 1'b0;
    check("flush_valid", {31'b0, out_inst_valid}, 32'd0);
    check("flush_ce", {31'b0, out_mem_ce}, 32'd0);
    step();
    check("redir_ce", {31'b0, out_mem_ce}, 32'd1);
    check("redir_addr", out_mem_addr, 32'h100);
    in_mem_ce = 1'b1; in_mem_data = 32'h11111111;
    step();
    in_mem_ce = 1'b0;
    check("redir_inst", out_inst, 32'h11111111);
    check("redir_pc", out_pc, 32'h100);
    step();
    check("req_104", out_mem_addr, 32'h104);

    // response coincident with misbranch is discarded
    in_rob_misbranch = 1'b1; in_rob_newpc = 32'h0;
    in_mem_ce = 1'b1; in_mem_data = 32'h22222222;
    step();
    in_rob_misbranch = 1'b0; in_mem_ce = 1'b0;
    check("coinc_valid", {31'b0, out_inst_valid}, 32'd0);

    // 0x0 was evicted by 0x100: conflict miss
    step();
    check("conflict_ce", {31'b0, out_mem_ce}, 32'd1);
    check("conflict_addr", out_mem_addr, 32'h0);
    in_mem_ce = 1'b1; in_mem_data = 32'h00500093;
    step();
    in_mem_ce = 1'b0;
    check("refill_valid", {31'b0, out_inst_valid}, 32'd1);
    check("refill_pc", out_pc, 32'h0);

    // loop back to 0
    in_rob_misbranch = 1'b1; in_rob_newpc = 32'h0;
    step();
    in_rob_misbranch = 1'b0;
    check("loop_ce", {31'b0, out_mem_ce}, 32'd0);
    step();
`ifdef FETCHER_ICACHE_EN
    check("hit_valid", {31'b0, out_inst_valid}, 32'd1);
    check("hit_inst", out_inst, 32'h00500093);
    check("hit_pc", out_pc, 32'h0);
    check("hit_no_ce", {31'b0, out_mem_ce}, 32'd0);
`else
    check("nohit_valid", {31'b0, out_inst_valid}, 32'd0);
    check("nohit_ce", {31'b0, out_mem_ce}, 32'd1);
    check("nohit_addr", out_mem_addr, 32'h0);
`endif

    // stall at pc 0x8
    in_rob_misbranch = 1'b1; in_rob_newpc = 32'h8;
    step();
    in_rob_misbranch = 1'b0;
    step();
    check("stall_addr", out_mem_addr, 32'h8);
    check("stall_ce", {31'b0, out_mem_ce}, 32'd1);
    step();
    in_queue_full = 1'b1; in_mem_ce = 1'b1; in_mem_data = 32'h12345678;
    step();
    in_mem_ce = 1'b0;
    check("hold_valid0", {31'b0, out_inst_valid}, 32'd0);
    step();
    check("hold_valid1", {31'b0, out_inst_valid}, 32'd0);
    check("hold_ce", {31'b0, out_mem_ce}, 32'd0);
    in_queue_full = 1'b0;
    step();
    check("release_valid", {31'b0, out_inst_valid}, 32'd1);
    check("release_inst", out_inst, 32'h12345678);
    check("release_pc", out_pc, 32'h8);
    step();
    check("release_once", {31'b0, out_inst_valid}, 32'd0);
    check("req_c", out_mem_addr, 32'hC);
    step();

    // rdy low in WAIT_MEM freezes everything, stray in_mem_ce ignored
    rdy = 1'b0;
    ce_snap = ce_count;
    in_mem_ce = 1'b1; in_mem_data = 32'hBAD0BAD0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("frz_ce", {31'b0, out_mem_ce}, 32'd0);
      check("frz_addr", out_mem_addr, 32'hC);
      check("frz_valid", {31'b0, out_inst_valid}, 32'd0);
    end
    check("frz_noreissue", ce_count, ce_snap);
    in_mem_data = 32'hCAFEF00D;
    rdy = 1'b1;
    step();
    in_mem_ce = 1'b0;
    check("thaw_inst", out_inst, 32'hCAFEF00D);
    check("thaw_pc", out_pc, 32'hC);

    // reset while waiting drops the request
    step();
    check("req_10", out_mem_addr, 32'h10);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_ce", {31'b0, out_mem_ce}, 32'd0);
    check("rst2_addr", out_mem_addr, 32'h0);
    step();
    check("post_rst_ce", {31'b0, out_mem_ce}, 32'd1);
    check("post_rst_addr", out_mem_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
